backprop_update_stack: RTL

- Parametrised successor to the backprop stack.
- During the backward pass, stores per-layer delta vectors (SIZE lanes, signed fixed point) in a LIFO.
- On drain, pops the stack newest-layer-first and streams per-row weight updates (lr·delta·x) to the weight-update port.
- Adds configurable depth, lane count and fraction bits, a saturate/wrap mode, and valid/ready handshakes on both sides.

---
 rtl/backprop_pkg.sv | 37 +++
 rtl/bp_lane_mul.sv | 34 +++
 rtl/backprop_update_stack.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/backprop_pkg.sv
// Shared types and fixed-point helpers for the backprop update stack.
// FSM encodings, stack-pointer sizing, lane slicing and saturate/wrap narrowing.
package backprop_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_POP  = 3'd1;
    localparam state_t ST_REQ  = 3'd2;
    localparam state_t ST_CALC = 3'd3;
    localparam state_t ST_OUT  = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    // Pointer must represent 0..depth inclusive so "full" is distinguishable from "empty".
    function automatic int unsigned sp_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Lane 0 occupies the most significant slice of a packed vector.
    function automatic int unsigned lane_msb(input int unsigned lane, input int unsigned size,
                                             input int unsigned w);
        return (size - lane) * w - 1;
    endfunction

    // Narrow a sign-extended value to w bits: clamp when sat is set, otherwise keep low bits.
    function automatic logic [63:0] fx_narrow(input logic signed [63:0] v, input int unsigned w,
                                              input logic sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (sat && (v > hi)) return hi;
        if (sat && (v < lo)) return lo;
        return v;
    endfunction

endpackage

// File: rtl/bp_lane_mul.sv
// One lane of the weight-update datapath: delta*lr*x, floor-shifted back to the
// fixed-point grid and then saturated or wrapped to DATA_SIZE bits.
module bp_lane_mul
    import backprop_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic [DATA_SIZE-1:0] delta_i,
    input  logic [DATA_SIZE-1:0] lr_i,
    input  logic [DATA_SIZE-1:0] x_i,
    input  logic                 sat_mode_i,
    output logic [DATA_SIZE-1:0] result_o
);

    localparam int unsigned PW = 3 * DATA_SIZE;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic signed [63:0]   wide;
    logic        [63:0]   narrow;
    logic                 unused_narrow_hi;

    always_comb begin
        prod     = PW'($signed(delta_i)) * PW'($signed(lr_i)) * PW'($signed(x_i));
        shifted  = prod >>> (2 * FRAC_BITS);
        wide     = 64'(shifted);
        narrow   = fx_narrow(wide, DATA_SIZE, sat_mode_i);
        result_o = narrow[DATA_SIZE-1:0];
    end

    assign unused_narrow_hi = ^narrow[63:DATA_SIZE];

endmodule

// File: rtl/backprop_update_stack.sv
// LIFO of per-layer delta vectors; on drain, pops newest-first and streams
// lr*delta*x update words per input row over a valid/ready port.
module backprop_update_stack
    import backprop_pkg::*;
#(
    parameter int unsigned MAX_LAYERS = 4,
    parameter int unsigned SIZE       = 3,
    parameter int unsigned DATA_SIZE  = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned LAYER_W    = 8,
    parameter int unsigned ROW_W      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      train_en,
    input  logic                      sat_mode,
    input  logic [DATA_SIZE-1:0]      learning_rate,
    input  logic                      push_valid,
    output logic                      push_ready,
    input  logic [SIZE*DATA_SIZE-1:0] push_delta,
    input  logic [LAYER_W-1:0]        push_layer,
    input  logic [ROW_W-1:0]          push_rows,
    input  logic                      drain_start,
    output logic                      in_req_valid,
    output logic [LAYER_W-1:0]        in_req_layer,
    output logic [ROW_W-1:0]          in_req_row,
    input  logic [DATA_SIZE-1:0]      in_data,
    output logic                      upd_valid,
    input  logic                      upd_ready,
    output logic [LAYER_W-1:0]        upd_layer,
    output logic [ROW_W-1:0]          upd_row,
    output logic [SIZE*DATA_SIZE-1:0] upd_value,
    output logic                      empty,
    output logic                      full,
    output logic                      overflow,
    output logic                      done
);

    localparam int unsigned SP_W  = sp_width(MAX_LAYERS);
    localparam int unsigned IDX_W = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
    localparam int unsigned VEC_W = SIZE * DATA_SIZE;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(MAX_LAYERS);

    logic [VEC_W-1:0]   mem_delta [MAX_LAYERS];
    logic [LAYER_W-1:0] mem_layer [MAX_LAYERS];
    logic [ROW_W-1:0]   mem_rows  [MAX_LAYERS];

    state_t             state_q, state_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic               overflow_q, overflow_d;
    logic [VEC_W-1:0]   wk_delta_q, wk_delta_d;
    logic [LAYER_W-1:0] wk_layer_q, wk_layer_d;
    logic [ROW_W-1:0]   wk_rows_q, wk_rows_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [VEC_W-1:0]   upd_value_q, upd_value_d;

    logic               push_fire;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [ROW_W:0]     row_inc;
    logic [VEC_W-1:0]   lane_result;

    assign empty        = (sp_q == '0);
    assign full         = (sp_q == SP_FULL);
    assign push_ready   = (state_q == ST_IDLE) & train_en & ~full;
    assign push_fire    = push_ready & push_valid;
    assign wr_idx       = IDX_W'(sp_q);
    assign rd_idx       = IDX_W'(sp_q - SP_W'(1));
    assign row_inc      = {1'b0, row_q} + {{ROW_W{1'b0}}, 1'b1};

    assign in_req_valid = (state_q == ST_REQ);
    assign in_req_layer = wk_layer_q;
    assign in_req_row   = row_q;
    assign upd_valid    = (state_q == ST_OUT);
    assign upd_layer    = wk_layer_q;
    assign upd_row      = row_q;
    assign upd_value    = upd_value_q;
    assign overflow     = overflow_q;
    assign done         = (state_q == ST_DONE);

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        localparam int unsigned MSB = lane_msb(i, SIZE, DATA_SIZE);
        bp_lane_mul #(
            .DATA_SIZE(DATA_SIZE),
            .FRAC_BITS(FRAC_BITS)
        ) u_lane (
            .delta_i   (wk_delta_q[MSB -: DATA_SIZE]),
            .lr_i      (learning_rate),
            .x_i       (in_data),
            .sat_mode_i(sat_mode),
            .result_o  (lane_result[MSB -: DATA_SIZE])
        );
    end

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        overflow_d  = overflow_q;
        wk_delta_d  = wk_delta_q;
        wk_layer_d  = wk_layer_q;
        wk_rows_d   = wk_rows_q;
        row_d       = row_q;
        upd_value_d = upd_value_q;

        if (push_fire) sp_d = sp_q + SP_W'(1);
        if ((state_q == ST_IDLE) && push_valid && full) overflow_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (drain_start && train_en) state_d = ST_POP;
            end
            ST_POP: begin
                if (empty) begin
                    state_d = ST_DONE;
                end else begin
                    sp_d       = sp_q - SP_W'(1);
                    wk_delta_d = mem_delta[rd_idx];
                    wk_layer_d = mem_layer[rd_idx];
                    wk_rows_d  = mem_rows[rd_idx];
                    row_d      = '0;
                    // Layers with no input rows produce no updates; go straight to the next pop.
                    state_d    = (mem_rows[rd_idx] == '0) ? ST_POP : ST_REQ;
                end
            end
            ST_REQ:  state_d = ST_CALC;
            ST_CALC: begin
                upd_value_d = lane_result;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (upd_ready) begin
                    if (row_inc < {1'b0, wk_rows_q}) begin
                        row_d   = row_inc[ROW_W-1:0];
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_POP;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sp_q        <= '0;
            overflow_q  <= 1'b0;
            wk_delta_q  <= '0;
            wk_layer_q  <= '0;
            wk_rows_q   <= '0;
            row_q       <= '0;
            upd_value_q <= '0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            overflow_q  <= overflow_d;
            wk_delta_q  <= wk_delta_d;
            wk_layer_q  <= wk_layer_d;
            wk_rows_q   <= wk_rows_d;
            row_q       <= row_d;
            upd_value_q <= upd_value_d;
        end
    end

    // Storage needs no reset: the pointer alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_delta[wr_idx] <= push_delta;
            mem_layer[wr_idx] <= push_layer;
            mem_rows[wr_idx]  <= push_rows;
        end
    end

endmodule
